// File: rtl/stream_feeder_pkg.sv
// Shared constants, frame-length helper and FSM state type for stream_feeder.
package stream_feeder_pkg;

  localparam int HEAD_LEN     = 6;
  localparam int BODY_LEN     = 64;
  localparam int FLAG_TIMEOUT = 4;
  localparam int CNT_W        = 15;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    BODY,
    DRAIN,
    DONE
  } state_e;

  function automatic cnt_t frame_len(input logic [7:0] nb);
    return cnt_t'(HEAD_LEN) + cnt_t'(nb) * cnt_t'(BODY_LEN);
  endfunction

endpackage

// File: rtl/feeder_skid.sv
// One-entry skid register: parks a returning SRAM beat while the consumer stalls.
module feeder_skid #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: the data register is reset as well, so nothing stale can surface after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (drain_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/stream_feeder.sv
// Streams header + num_blocks bodies from SRAM to the datapath with hold/skid handling.
// Optional `FEEDER_FLAG_CHECK_EN`: counts ret_flag pulses and raises sticky err on mismatch.
module stream_feeder
  import stream_feeder_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_blocks,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  input  logic              ret_flag,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        nblk_q;
  cnt_t              total_q, rd_cnt_q, out_cnt_q;
  logic              rd_vld_q;
  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic              accept, rd_en, head_last, last_issue, last_beat, drain_exit;

  assign accept     = (state_q == IDLE) && start;
  assign rd_en      = ((state_q == HEAD) || (state_q == BODY)) && (rd_cnt_q != total_q)
                      && !hold && !skid_full;
  assign head_last  = rd_en && (rd_cnt_q == cnt_t'(HEAD_LEN - 1));
  assign last_issue = rd_en && (rd_cnt_q == total_q - cnt_t'(1));
  assign last_beat  = out_vld && (out_cnt_q == total_q - cnt_t'(1));

  // A beat returning under hold is parked; reads stay blocked until it is emitted.
  feeder_skid #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (rd_vld_q & hold),
    .drain_i (skid_full & ~hold),
    .data_i  (mem_rd_data),
    .full_o  (skid_full),
    .data_o  (skid_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HEAD;
      HEAD:    if (head_last) state_d = (nblk_q != 8'd0) ? BODY : DRAIN;
      BODY:    if (last_issue) state_d = DRAIN;
      DRAIN:   if (drain_exit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = rd_en;
    mem_addr  = rd_en ? base_q + rd_cnt_q[ADDR_W-1:0] : '0;
    out_vld   = (rd_vld_q | skid_full) & ~hold;
    out_data  = out_vld ? (skid_full ? skid_data : mem_rd_data) : '0;
    busy      = (state_q == HEAD) || (state_q == BODY) || (state_q == DRAIN);
    done      = (state_q == DONE);
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      nblk_q    <= '0;
      total_q   <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      if (accept) begin
        base_q    <= base_addr;
        nblk_q    <= num_blocks;
        total_q   <= frame_len(num_blocks);
        rd_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (rd_en)   rd_cnt_q  <= rd_cnt_q + cnt_t'(1);
        if (out_vld) out_cnt_q <= out_cnt_q + cnt_t'(1);
      end
    end
  end

`ifdef FEEDER_FLAG_CHECK_EN
  logic [8:0] flag_cnt_q, flag_nxt;
  logic [2:0] tmo_q;
  logic       tail_q, err_q, flag_match, flag_tmo;

  assign flag_nxt   = flag_cnt_q + {8'd0, busy & ret_flag};
  assign flag_match = (flag_nxt == {1'b0, nblk_q});
  assign flag_tmo   = (tmo_q == 3'(FLAG_TIMEOUT - 1));
  // The flag wait opens on the last beat and closes on a count match or the timeout.
  assign drain_exit = (last_beat || tail_q) && (flag_match || flag_tmo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_cnt_q <= '0;
      tmo_q      <= '0;
      tail_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      flag_cnt_q <= '0;
      tmo_q      <= '0;
      tail_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      flag_cnt_q <= flag_nxt;
      if (last_beat) tail_q <= 1'b1;
      if ((state_q == DRAIN) && (last_beat || tail_q)) tmo_q <= tmo_q + 3'd1;
      if ((state_q == DRAIN) && drain_exit) err_q <= !flag_match;
    end
  end

  assign err = err_q;
`else
  logic unused_ret_flag;
  assign unused_ret_flag = ret_flag;
  assign drain_exit      = last_beat;
  assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_stream_feeder.sv
// Scoreboard bench for stream_feeder: expected addresses/beats queued per frame, monitor compares.
module tb_stream_feeder;

  localparam int DW = 64;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    num_blocks = '0;
  logic          hold = 1'b0;
  logic          ret_flag = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rd_en, out_vld, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] out_data;

  stream_feeder #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_blocks(num_blocks), .hold(hold), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .out_vld(out_vld), .out_data(out_data), .busy(busy),
    .done(done), .ret_flag(ret_flag), .err(err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int frame_beats = 0;
  int last_beat_cyc = 0;
  int done_cyc = -1;
  int start_cyc = 0;
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) begin
        check("rd_during_hold", hold, 1'b0);
        check("rd_expected", exp_addr_q.size() != 0, 1'b1);
        if (exp_addr_q.size() != 0) check("rd_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (out_vld) begin
        check("vld_during_hold", hold, 1'b0);
        check("beat_expected", exp_data_q.size() != 0, 1'b1);
        if (exp_data_q.size() != 0) check("beat_data", out_data, exp_data_q.pop_front());
        frame_beats++;
        last_beat_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic push_frame(input logic [AW-1:0] base, input int total);
    logic [AW-1:0] a;
    for (int i = 0; i < total; i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
    end
  endtask

  // mode 0: no hold, 1: random hold, 2: 3-cycle hold once 10 beats are out
  task automatic run_frame(input logic [AW-1:0] base, input logic [7:0] nb,
                           input int mode, input int npulse);
    int total, gap, hs, budget;
    logic exp_err;
    total = 6 + 64 * int'(nb);
`ifdef FEEDER_FLAG_CHECK_EN
    gap = (npulse == int'(nb)) ? 1 : 4;
    exp_err = (npulse != int'(nb));
`else
    gap = 1;
    exp_err = 1'b0;
`endif
    frame_beats = 0;
    done_cyc = -1;
    hs = 0;
    push_frame(base, total);
    start = 1'b1;
    base_addr = base;
    num_blocks = nb;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    base_addr = AW'($urandom);
    num_blocks = 8'($urandom);
    @(negedge clk);
    check("first_rd_en", mem_rd_en, 1'b1);
    check("busy_after_start", busy, 1'b1);
    check("no_vld_first_cycle", out_vld, 1'b0);
    @(negedge clk);
    check("first_vld_latency", out_vld, 1'b1);
    budget = 4 * total + 200;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (done_cyc >= 0) break;
      #1;
      start = (k == 3);
      ret_flag = (k == 20 && npulse > 0) || (k == 90 && npulse > 1);
      if (mode == 1) hold = ($urandom_range(0, 3) == 0);
      else if (mode == 2) begin
        if (frame_beats >= 10 && hs < 3) begin
          hold = 1'b1;
          hs++;
        end else hold = 1'b0;
      end
    end
    #1;
    hold = 1'b0;
    ret_flag = 1'b0;
    start = 1'b0;
    check("done_seen", done_cyc >= 0, 1'b1);
    check("beat_count", frame_beats, total);
    check("queue_drained", exp_data_q.size(), 0);
    check("done_gap", done_cyc - last_beat_cyc, gap);
    if (mode == 0) check("last_beat_offset", last_beat_cyc - start_cyc, total);
    if (mode == 2) check("stall_last_offset", last_beat_cyc - start_cyc, total + 4);
    @(negedge clk);
    check("done_single", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);
    check("err", err, exp_err);
    exp_data_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_addr", mem_addr, '0);
    check("rst_vld", out_vld, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(12'h100, 8'd1, 0, 0);
    run_frame(12'h7A0, 8'd0, 0, 0);
    run_frame(12'h200, 8'd1, 2, 0);
    run_frame(12'hFFE, 8'd1, 0, 0);
`ifdef FEEDER_FLAG_CHECK_EN
    run_frame(12'h300, 8'd2, 0, 2);
    run_frame(12'h300, 8'd2, 0, 1);
`endif

    // reset mid-frame, during the body
    frame_beats = 0;
    push_frame(12'h400, 70);
    start = 1'b1;
    base_addr = 12'h400;
    num_blocks = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (frame_beats >= 20) break;
    end
    check("reached_body", frame_beats >= 20, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rd_en", mem_rd_en, 1'b0);
    check("midrst_addr", mem_addr, '0);
    check("midrst_vld", out_vld, 1'b0);
    check("midrst_data", out_data, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    exp_data_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(12'h400, 8'd1, 0, 0);

    for (int r = 0; r < 6; r++)
      run_frame(AW'($urandom_range(0, (1 << AW) - 1)), 8'($urandom_range(0, 3)), 1, 0);
    run_frame(AW'($urandom), 8'd255, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_feeder.md
# stream_feeder

Sequencing source for the top-4 path-projection datapath. Streams one frame per start from the feature SRAM into the datapath: a 6-beat header, then `num_blocks` bodies of 64 beats, via `out_vld`/`out_data`. The frame length matches the datapath's beat counter, which counts to 69 and wraps to 6. The block drives that counter's `in_vld` and, optionally, cross-checks the datapath's per-block completion flag.

## Interface
- `DATA_W`, 64: beat width.
- `ADDR_W`, 12: SRAM address width.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: frame request; sampled only in IDLE.
- `base_addr`  in  ADDR_W: frame start address; captured on accepted start.
- `num_blocks`  in  8: body block count; captured on accepted start; 0 means header only.
- `hold`  in  1: downstream stall; no beat may be presented while high.
- `mem_rd_en`  out  1: SRAM read strobe; read data is valid the next cycle.
- `mem_addr`  out  ADDR_W: SRAM read address.
- `mem_rd_data`  in  DATA_W: SRAM read data.
- `out_vld`  out  1: beat valid; this drives the datapath `in_vld`.
- `out_data`  out  DATA_W: beat payload.
- `busy`  out  1: high from an accepted start until `done`.
- `done`  out  1: single-cycle end-of-frame pulse.
- `ret_flag`  in  1: datapath block-complete pulse; used only with `FEEDER_FLAG_CHECK_EN`.
- `err`  out  1: sticky flag-count mismatch; used only with `FEEDER_FLAG_CHECK_EN`.

## Operation
- **States:**
  - IDLE goes to HEAD on `start`.
  - HEAD goes to BODY after 6 reads are issued when `num_blocks`>0, otherwise to DRAIN.
  - BODY goes to DRAIN after 64·`num_blocks` reads are issued.
  - DRAIN goes to DONE when the last beat has been emitted and (with the check feature) the flag wait has closed.
  - DONE goes to IDLE unconditionally.
- **Frame size and addressing:**
  - Total beats = 6 + 64·`num_blocks`, maximum 16326.
  - Beat i reads `base_addr`+i, wrapping modulo 2^ADDR_W.
- **Read issue:** a read is issued in a cycle iff all of the following hold:
  - state is HEAD or BODY;
  - reads remain;
  - `hold`=0;
  - the skid register is empty.
- **Skid register:**
  - One entry, holding at most one read in flight.
  - Returning data is emitted directly if `hold`=0 and the skid is empty; otherwise it is captured in the skid.
  - A full skid is emitted in the first cycle with `hold`=0. Reads resume the cycle after it empties.
- **Output:**
  - `out_vld` = (returning data or skid full) & ~`hold`. This is a combinational path from `hold`, which is intentional.
  - `out_data` is taken from the skid when it is full, otherwise from `mem_rd_data`.
  - Beats are emitted strictly in address order, with no duplication or loss.
- **Start handling:** `start` during any state other than IDLE is ignored; captured parameters stay fixed for the frame.
- **Reset:** asynchronous at any point, mid-frame included. All outputs go to 0, state goes to IDLE, counters and skid clear, `err` clears.

## Timing
- Reset values: `mem_rd_en`, `mem_addr`, `out_vld`, `out_data`, `busy`, `done`, `err` all 0.
- With `start` sampled at edge E0 and `hold`=0:
  - `mem_rd_en` is high in cycle E0–E1.
  - The first `out_vld` is in cycle E1–E2, i.e. 2-cycle latency.
  - Beats are then back-to-back.
- Without the check feature, `done` pulses in the cycle after the last beat; `busy` drops with `done`.
- A `hold` of N cycles delays all subsequent beats by N cycles, plus 1 extra cycle when the skid captured data.

## Configuration
- **`FEEDER_FLAG_CHECK_EN` defined:**
  - `ret_flag` pulses are counted while `busy`.
  - DRAIN waits until the count equals `num_blocks` or 4 cycles have passed since the last beat, whichever comes first.
  - On entering DONE, `err` is set if the count ≠ `num_blocks`. `err` holds until the next accepted start or reset.
- **Undefined:**
  - The `ret_flag` input is ignored.
  - `err` is tied 0.
  - DRAIN exits on the last beat.

## Structure
- Package `stream_feeder_pkg` holds:
  - `HEAD_LEN`=6, `BODY_LEN`=64, `FLAG_TIMEOUT`=4;
  - the state enum (IDLE, HEAD, BODY, DRAIN, DONE).
- One sub-module, `feeder_skid`: 1-entry skid register with data, full bit, load and drain controls.

## Test plan
- Frame of one block, single beat stream:
  - Stimulus: `base_addr`=0x100, `num_blocks`=1, `hold`=0, start.
  - Response: 70 consecutive `out_vld` starting 2 cycles after start; addresses 0x100–0x145; `done` one cycle after beat 70.
- Header-only frame:
  - Stimulus: `num_blocks`=0.
  - Response: exactly 6 beats, then `done`; state never enters BODY.
- Stall mid-frame:
  - Stimulus: `hold`=1 for 3 cycles starting at beat 10.
  - Response: `out_vld`=0 during the hold; beat 10 data preserved; 70 beats total, in order, none duplicated.
- Address wrap:
  - Stimulus: `base_addr`=0xFFE, ADDR_W=12.
  - Response: addresses 0xFFE, 0xFFF, 0x000, …
- Flag check (with `FEEDER_FLAG_CHECK_EN`):
  - Stimulus: `num_blocks`=2 with two `ret_flag` pulses.
    - Response: `err`=0.
  - Stimulus: `num_blocks`=2 with one `ret_flag` pulse.
    - Response: `err`=1 and `done` 4 cycles after the last beat.
- Reset mid-frame:
  - Stimulus: `rst_n` low during BODY.
  - Response: outputs 0 immediately; a new start replays from the header.
